// File: rtl/executor_merge.sv
// executor_merge: on lock-down, ORs the 4x4 piece into matrix memory by read-modify-write, one row per cycle.
// Latency: 4 merge cycles after the accept edge, done_o in the 5th cycle, ready_o high again in the 6th.
// Backpressure: v_i taken only while ready_o=1, else dropped; EXECUTOR_MERGE_COLLIDE_EN adds the collide_o flag.
module executor_merge #(
  parameter int width_p  = 16,
  parameter int height_p = 32,
  parameter int debug_p  = 0
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        v_i,
  output logic                        ready_o,
  input  logic [15:0]                 piece_i,
  input  logic [$clog2(width_p)-1:0]  pos_x_i,
  input  logic [$clog2(height_p)-1:0] pos_y_i,
  output logic                        done_o,
  output logic                        collide_o,
  output logic [$clog2(height_p)-1:0] mm_read_addr_o,
  input  logic [width_p-1:0]          mm_read_data_i,
  output logic [$clog2(height_p)-1:0] mm_write_addr_o,
  output logic [width_p-1:0]          mm_write_data_o,
  output logic                        mm_write_v_o
);

  localparam int x_w_lp = $clog2(width_p);
  localparam int y_w_lp = $clog2(height_p);

  typedef enum logic [1:0] {
    eIDLE  = 2'd0,
    eMerge = 2'd1,
    eDone  = 2'd2
  } state_e;

  state_e              r_state;
  state_e              w_state_n;
  logic [1:0]          r_row_cnt;
  logic [15:0]         r_piece;
  logic [x_w_lp-1:0]   r_pos_x;
  logic [y_w_lp-1:0]   r_pos_y;

  logic                w_accept;
  logic [3:0]          w_nibble;
  logic [y_w_lp:0]     w_row;
  logic                w_row_ok;
  logic [width_p-1:0]  w_mask;

  assign w_accept = (r_state == eIDLE) && v_i;

  // Piece row currently being merged and the matrix row it lands on; the
  // extra MSB on w_row keeps off-bottom rows from aliasing onto the top.
  assign w_nibble = r_piece[{r_row_cnt, 2'b00} +: 4];
  assign w_row    = {1'b0, r_pos_y} + {{(y_w_lp-1){1'b0}}, r_row_cnt};
  assign w_row_ok = (w_row < (y_w_lp+1)'(height_p));

`ifdef EXECUTOR_MERGE_COLLIDE_EN
  // Double-width shift so bits pushed past the right edge stay visible.
  logic [2*width_p-1:0] w_shift_full;
  logic                 w_spill;
  logic                 w_hit;
  logic                 r_collide;

  assign w_shift_full = (2*width_p)'(w_nibble) << r_pos_x;
  assign w_mask       = w_shift_full[width_p-1:0];
  assign w_spill      = |w_shift_full[2*width_p-1:width_p];
  assign w_hit        = (|(mm_read_data_i & w_mask)) || w_spill ||
                        ((w_nibble != 4'd0) && !w_row_ok);

  // Sticky collision flag: cleared on accept, accumulates over the 4 merge rows
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_collide <= 1'b0;
    end else if (w_accept) begin
      r_collide <= 1'b0;
    end else if ((r_state == eMerge) && w_hit) begin
      r_collide <= 1'b1;
    end
  end

  assign collide_o = r_collide;
`else
  assign w_mask    = width_p'(w_nibble) << r_pos_x;
  assign collide_o = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= eIDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  // Next-state and state-decoded outputs
  always_comb begin
    w_state_n    = r_state;
    ready_o      = 1'b0;
    done_o       = 1'b0;
    mm_write_v_o = 1'b0;
    case (r_state)
      eIDLE: begin
        ready_o = 1'b1;
        if (v_i) w_state_n = eMerge;
      end
      eMerge: begin
        // Empty piece rows and rows below the matrix are never written.
        mm_write_v_o = w_row_ok && (w_mask != '0);
        if (r_row_cnt == 2'd3) w_state_n = eDone;
      end
      eDone: begin
        done_o    = 1'b1;
        w_state_n = eIDLE;
      end
      default: w_state_n = eIDLE;
    endcase
  end

  // Request capture on accept and row counter advance during merge
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_piece   <= '0;
      r_pos_x   <= '0;
      r_pos_y   <= '0;
      r_row_cnt <= '0;
    end else if (w_accept) begin
      r_piece   <= piece_i;
      r_pos_x   <= pos_x_i;
      r_pos_y   <= pos_y_i;
      r_row_cnt <= '0;
    end else if (r_state == eMerge) begin
      r_row_cnt <= r_row_cnt + 2'd1;
    end
  end

  // Read and write share one address: the read data returns combinationally
  // and is written back with the piece bits OR-ed in.
  assign mm_read_addr_o  = w_row[y_w_lp-1:0];
  assign mm_write_addr_o = w_row[y_w_lp-1:0];
  assign mm_write_data_o = mm_read_data_i | w_mask;

  // Debug build: the done state must always fall straight back to idle
  generate
    if (debug_p != 0) begin : g_debug
      a_done_to_idle: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (r_state == eDone) |=> (r_state == eIDLE));
    end
  endgenerate

endmodule

// File: tb/tb_executor_merge.sv
module tb_executor_merge;

  localparam int H = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v_i = 1'b0;
  logic [15:0] piece_i = '0;
  logic [3:0]  pos_x_i = '0;
  logic [4:0]  pos_y_i = '0;
  logic        ready_o, done_o, collide_o, mm_write_v_o;
  logic [4:0]  mm_read_addr_o, mm_write_addr_o;
  logic [15:0] mm_read_data_i, mm_write_data_o;

  logic        pre_we = 1'b0;
  logic [4:0]  pre_addr = '0;
  logic [15:0] pre_data = '0;

  logic [15:0] mem [H];
  logic [15:0] mem_model [H];
  int          wr_count = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  executor_merge dut (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v_i), .ready_o(ready_o),
    .piece_i(piece_i), .pos_x_i(pos_x_i), .pos_y_i(pos_y_i),
    .done_o(done_o), .collide_o(collide_o),
    .mm_read_addr_o(mm_read_addr_o), .mm_read_data_i(mm_read_data_i),
    .mm_write_addr_o(mm_write_addr_o), .mm_write_data_o(mm_write_data_o),
    .mm_write_v_o(mm_write_v_o)
  );

  // Matrix memory: async read, sync write, plus a bench-side preload port.
  assign mm_read_data_i = mem[mm_read_addr_o];
  always @(posedge clk) begin
    if (mm_write_v_o) begin
      mem[mm_write_addr_o] <= mm_write_data_o;
      wr_count <= wr_count + 1;
    end else if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [3:0]       wv;
    logic [3:0][4:0]  wa;
    logic [3:0][15:0] wd;
    logic             col;
  } plan_t;

  plan_t plan;
  int    m_busy = 0;   // 0 idle, 1..4 merge cycle, 5 done cycle
  logic  col_valid = 1'b0;
  logic  exp_col = 1'b0;

  function automatic plan_t make_plan(input logic [15:0] pc, input int x, input int y);
    plan_t p;
    int row;
    logic [3:0] nib;
    logic [31:0] sh;
    logic [15:0] m;
    p = '0;
    for (int r = 0; r < 4; r++) begin
      row = y + r;
      nib = pc[4*r +: 4];
      sh  = {28'd0, nib} << x;
      m   = sh[15:0];
      if (row < H && m != 16'd0) begin
        p.wv[r] = 1'b1;
        p.wa[r] = row[4:0];
        p.wd[r] = mem_model[row] | m;
      end
      if (nib != 4'd0 && (row >= H || sh[31:16] != 16'd0 || (mem_model[row] & m) != 16'd0))
        p.col = 1'b1;
    end
`ifndef EXECUTOR_MERGE_COLLIDE_EN
    p.col = 1'b0;
`endif
    return p;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy    <= 0;
      col_valid <= 1'b0;
    end else begin
      if (pre_we) mem_model[pre_addr] <= pre_data;
      if (m_busy == 0) begin
        if (v_i) begin
          plan      <= make_plan(piece_i, int'(pos_x_i), int'(pos_y_i));
          m_busy    <= 1;
          col_valid <= 1'b0;
        end
      end else begin
        if (m_busy <= 4 && plan.wv[m_busy-1])
          mem_model[plan.wa[m_busy-1]] <= plan.wd[m_busy-1];
        if (m_busy == 4) begin
          col_valid <= 1'b1;
          exp_col   <= plan.col;
        end
        m_busy <= (m_busy == 5) ? 0 : m_busy + 1;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    int   idx;
    logic ewv;
    if (rst_n) begin
      idx = (m_busy >= 1 && m_busy <= 4) ? m_busy - 1 : 0;
      ewv = (m_busy >= 1 && m_busy <= 4) ? plan.wv[idx] : 1'b0;
      chk("ready", ready_o, m_busy == 0);
      chk("done", done_o, m_busy == 5);
      chk("wr_v", mm_write_v_o, ewv);
      if (ewv) begin
        chk("wr_addr", mm_write_addr_o, plan.wa[idx]);
        chk("wr_data", mm_write_data_o, plan.wd[idx]);
      end
      if (m_busy == 0 || col_valid)
        chk("collide", collide_o, col_valid ? exp_col : 1'b0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic preload(input logic [4:0] a, input logic [15:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic do_merge(input logic [15:0] pc, input logic [3:0] x, input logic [4:0] y,
                          output int dc, output int rc, output logic col);
    int k;
    dc = 0; rc = 0; col = 1'b0;
    k = 0;
    while (!ready_o && k < 20) begin @(posedge clk); #1; k++; end
    v_i = 1'b1; piece_i = pc; pos_x_i = x; pos_y_i = y;
    @(posedge clk); #1;
    v_i = 1'b0; piece_i = 16'($urandom); pos_x_i = 4'($urandom); pos_y_i = 5'($urandom);
    for (k = 1; k <= 20 && rc == 0; k++) begin
      @(negedge clk);
      if (done_o && dc == 0) dc = k;
      if (ready_o) begin rc = k; col = collide_o; end
      @(posedge clk); #1;
    end
  endtask

  logic exp_c;
  initial begin
`ifdef EXECUTOR_MERGE_COLLIDE_EN
    exp_c = 1'b1;
`else
    exp_c = 1'b0;
`endif
  end

  initial begin
    int dc, rc, w0, ndone;
    logic col;

    #3;
    chk("rst_ready", ready_o, 1'b1);
    chk("rst_done", done_o, 1'b0);
    chk("rst_wr_v", mm_write_v_o, 1'b0);
    chk("rst_collide", collide_o, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < H; i++) preload(5'(i), 16'h0000);

    // Test 1: two-row piece at the bottom edge
    w0 = wr_count;
    do_merge(16'h0033, 4'd4, 5'd30, dc, rc, col);
    chk("t1_row30", mem[30], 16'h0030);
    chk("t1_row31", mem[31], 16'h0030);
    chk("t1_nwrites", wr_count - w0, 2);
    chk("t1_done_cycle", dc, 5);
    chk("t1_ready_cycle", rc, 6);

    // Test 2: existing row content, piece row off the bottom is empty
    preload(5'd31, 16'hFF00);
    w0 = wr_count;
    do_merge(16'h000F, 4'd0, 5'd31, dc, rc, col);
    chk("t2_row31", mem[31], 16'hFF0F);
    chk("t2_nwrites", wr_count - w0, 1);
    chk("t2_done_cycle", dc, 5);
    chk("t2_collide", col, 1'b0);

    // Test 3 / 6: overlap with an occupied cell
    preload(5'd20, 16'h0010);
    do_merge(16'h0010, 4'd4, 5'd19, dc, rc, col);
    chk("t3_row20", mem[20], 16'h0010);
    chk("t3_collide", col, exp_c);

    // Test 4: two bits pushed past the right edge
    do_merge(16'h000F, 4'd14, 5'd10, dc, rc, col);
    chk("t4_row10", mem[10], 16'hC000);
    chk("t4_collide", col, exp_c);

    // Test 5a: v_i held through the whole busy window gives one merge
    ndone = 0;
    v_i = 1'b1; piece_i = 16'h0001; pos_x_i = 4'd0; pos_y_i = 5'd0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done_o) ndone++;
      @(posedge clk); #1;
      if (i == 5) v_i = 1'b0;
    end
    chk("t5_done_count", ndone, 1);
    chk("t5_row0", mem[0], 16'h0001);

    // Test 5b: reset during the third merge row
    v_i = 1'b1; piece_i = 16'hFFFF; pos_x_i = 4'd0; pos_y_i = 5'd5;
    @(posedge clk); #1;
    v_i = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_ready", ready_o, 1'b1);
    chk("t5_rst_done", done_o, 1'b0);
    chk("t5_rst_wr_v", mm_write_v_o, 1'b0);
    chk("t5_rst_collide", collide_o, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done_o) ndone++;
      @(posedge clk); #1;
    end
    chk("t5_no_done", ndone, 0);
    chk("t5_row5", mem[5], 16'h000F);
    chk("t5_row6", mem[6], 16'h000F);
    chk("t5_row7", mem[7], 16'h0000);
    chk("t5_row8", mem[8], 16'h0000);

    // Randomized traffic, including requests while busy and random preloads
    for (int i = 0; i < 1500; i++) begin
      v_i     = ($urandom % 4) == 0;
      piece_i = 16'($urandom) & 16'($urandom);
      pos_x_i = 4'($urandom);
      pos_y_i = 5'($urandom);
      pre_we  = !v_i && ready_o && (($urandom % 3) == 0);
      pre_addr = 5'($urandom);
      pre_data = 16'($urandom) & 16'($urandom) & 16'($urandom);
      @(posedge clk); #1;
    end
    v_i = 1'b0; pre_we = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    for (int i = 0; i < H; i++) chk("final_mem", mem[i], mem_model[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
